seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, clocked successor of the combinational KGP_RISC ALU.
- Keeps the existing 4-bit opcode map and the zero/carry/sign/overflow flags, with these changes:
  - data width is a parameter;
  - operands are latched on a start/ready handshake;
  - results and flags are registered;
  - multiplication is an iterative shift-add engine returning the full 2*WIDTH product.
- Sits between register-file read and writeback in the multi-cycle datapath; the control FSM stalls on ready.

Parameters:
- WIDTH, 32, operand/result width (power of two, >= 8).
- SHAMT_W, $clog2(WIDTH), shift-amount field width (derived, not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request; accepted when start && ready.
- ready, output, 1, block can accept a request this cycle.
- opcode, input, 4, operation select (map below).
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B / shift amount.
- valid, output, 1, one-cycle pulse; result/flags are new this cycle.
- result, output, WIDTH, result (low half of product for multiplies).
- result_hi, output, WIDTH, high half of product; 0 for non-multiply ops.
- zero_flag, output, 1, result == 0 (multiplies: full 2*WIDTH product == 0).
- carry_flag, output, 1, adder carry-out.
- sign_flag, output, 1, MSB of result (multiplies: result_hi MSB).
- overflow_flag, output, 1, signed overflow.

Behaviour:
- Reset (synchronous, dominates everything, including mid-multiply):
  - outputs: ready=1, valid=0; result, result_hi and all flags = 0.
  - internal state: FSM=IDLE, iteration counter=0.
  - an in-flight multiply is discarded and produces no valid.
- Operand latching: a, b and opcode are captured at the acceptance edge; later input changes have no effect. start while ready=0 is ignored, not queued.
- Opcode map:
  - 0000 ADD, 0100 ADDI: a+b; carry=carry-out; overflow=(a[MSB]==b[MSB]) && (res[MSB]!=a[MSB]).
  - 0001 COMP, 0101 COMPI: ~b+1; carry=0; overflow=1 iff b==most-negative.
  - 1000 SUB (new): a+~b+1; carry=carry-out (1 = no borrow); overflow=(a[MSB]!=b[MSB]) && (res[MSB]!=a[MSB]).
  - 0010 MULU: unsigned a*b; overflow=(result_hi!=0).
  - 0011 MULS: signed a*b; overflow = result_hi is not the sign-extension of result[MSB].
  - 0110 AND, 0111 XOR, 1001 OR (new): bitwise.
  - 1010/1100 SLL, 1011/1101 SRL: logical shifts; 1110 SLA = SLL; 1111 SRA: arithmetic right shift.
    - Shift amount is the full b: if b >= WIDTH, logical shifts and SLA give 0; SRA gives all copies of a[MSB].
  - Flags for logic/shift ops: zero and sign from result; carry=0; overflow=0.
  - Unused codes: result=0, flags=0, valid still pulses.
- FSM states: IDLE, MUL, FIN.
  - IDLE, non-multiply accepted: result/flags registered at the acceptance edge; valid=1 the next cycle. Stay in IDLE with ready=1, so back-to-back ops run at 1/cycle.
  - IDLE, MULU/MULS accepted: go to MUL, ready=0.
    - Latch |a| and |b| for MULS, raw a and b for MULU.
    - Clear the 2*WIDTH accumulator; counter=0.
  - MUL: each cycle, if multiplier bit[counter] is set, add (multiplicand << counter) into the accumulator; counter++. After WIDTH iterations, go to FIN.
  - FIN: for MULS with a[MSB]!=b[MSB], negate the 2*WIDTH product; register result, result_hi and flags; go to IDLE.
  - valid=1 and ready=1 together in the cycle after FIN, so a new request can be accepted in that same cycle.
- Latency: non-multiply 1 cycle; multiply WIDTH+2 cycles from acceptance edge to valid (34 at WIDTH=32).
- Hold behaviour: outputs keep their last value until the next result; valid is high for exactly one cycle per accepted request.
- Arithmetic width: all add/sub done at WIDTH+1 bits to extract carry; product held at 2*WIDTH bits with no truncation before FIN.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_SRA, OP_SUB, OP_OR);
  - FSM state encoding (IDLE/MUL/FIN);
  - helper function is_mul(opcode).
- One sub-module, seq_multiplier: unsigned iterative shift-add core.
  - Ports: clk, rst, load, mcand, mplier, busy, done, product[2*WIDTH-1:0].
  - Sign handling (magnitude/negate) stays in seq_alu.

Test Plan:
- ADD a=32'h7FFF_FFFF, b=1 -> next cycle: valid=1, result=32'h8000_0000, overflow=1, sign=1, carry=0, zero=0.
- ADD a=32'hFFFF_FFFF, b=1 -> result=0, zero=1, carry=1, overflow=0. Then SUB a=5, b=7 issued the following cycle -> result=32'hFFFF_FFFE, carry=0, sign=1.
- MULS a=-3, b=7 -> ready low for 33 cycles; valid at cycle 34 with {result_hi,result}=64'hFFFF_FFFF_FFFF_FFEB, overflow=0, sign=1.
- MULU a=b=32'hFFFF_FFFF -> result_hi=32'hFFFF_FFFE, result=1, overflow=1. start pulses during busy are ignored (exactly one valid).
- SRA a=32'h8000_0000, b=40 -> result=32'hFFFF_FFFF. SRL same operands -> 0. SLL a=1, b=31 -> 32'h8000_0000.
- Reset: rst at MUL iteration 10 -> next cycle ready=1, no valid ever fires for the aborted op. A new ADD 2+3 then returns 5 with latency 1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: the 4-bit opcode map, the
// controller state encoding and a helper that classifies multiply opcodes.
package alu_pkg;

  // Every 4-bit code is assigned. The ALU still has a default branch that
  // returns zero result and zero flags, so any later re-mapping that frees a
  // code keeps a defined response.
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_COMP  = 4'b0001;
  localparam logic [3:0] OP_MULU  = 4'b0010;
  localparam logic [3:0] OP_MULS  = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_COMPI = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_SLLI  = 4'b1100;
  localparam logic [3:0] OP_SRLI  = 4'b1101;
  localparam logic [3:0] OP_SLA   = 4'b1110;
  localparam logic [3:0] OP_SRA   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_MULS);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the datapath controller and seq_alu.
//   start/opcode/a/b : request, accepted when start && ready
//   ready            : ALU can take a request this cycle
//   valid            : one-cycle pulse, result/flags are new this cycle
//   result/result_hi : result (low/high product halves for multiplies)
//   *_flag           : zero, carry, sign, overflow
// master = requester, slave = seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero_flag;
  logic             carry_flag;
  logic             sign_flag;
  logic             overflow_flag;

  modport master (
    output start, opcode, a, b,
    input  ready, valid, result, result_hi,
    input  zero_flag, carry_flag, sign_flag, overflow_flag
  );

  modport slave (
    input  start, opcode, a, b,
    output ready, valid, result, result_hi,
    output zero_flag, carry_flag, sign_flag, overflow_flag
  );
endinterface

// File: rtl/seq_alu_mult.sv
// Unsigned iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture mcand/mplier, clear the accumulator, start iterating
//   mcand    : multiplicand (unsigned)
//   mplier   : multiplier (unsigned)
//   busy     : iterations in progress
//   done     : the final iteration happens at the coming edge; product is
//              complete from the following cycle until the next load
//   product  : 2*WIDTH accumulator, never truncated
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt;

  // Combinational so the controller can leave its MUL state on the same
  // edge that retires the last partial product.
  assign done = busy && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt      <= '0;
      product  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (load) begin
      busy     <= 1'b1;
      cnt      <= '0;
      product  <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, mcand};
      mplier_q <= mplier;
    end else if (busy) begin
      if (mplier_q[cnt])
        product <= product + (mcand_q << cnt);
      cnt <= cnt + CNT_W'(1);
      if (done)
        busy <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Clocked, parameterised ALU. Single-cycle ops register their result at the
// acceptance edge (valid next cycle, back-to-back at one per cycle).
// MULU/MULS run on the shift-add engine: WIDTH+2 cycles from acceptance to
// valid, ready held low meanwhile; signs are stripped before the engine and
// re-applied to the full 2*WIDTH product in FIN.
//   clk, rst : clock, synchronous active-high reset (aborts a multiply)
//   bus      : seq_alu_if slave (start/ready request, valid-pulse response)
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state;

  logic [WIDTH-1:0] a, b;
  assign a = bus.a;
  assign b = bus.b;

  // ready is only high in IDLE, so acceptance implies IDLE.
  logic accept, mul_load, muls_in;
  assign accept   = bus.start && bus.ready;
  assign muls_in  = (bus.opcode == OP_MULS);
  assign mul_load = accept && is_mul(bus.opcode);

  // Magnitudes for MULS. The most-negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit operand.
  logic [WIDTH-1:0] mcand_in, mplier_in;
  assign mcand_in  = (muls_in && a[MSB]) ? (~a + WIDTH'(1)) : a;
  assign mplier_in = (muls_in && b[MSB]) ? (~b + WIDTH'(1)) : b;

  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  seq_multiplier #(.WIDTH(WIDTH)) u_mult (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .mcand  (mcand_in),
    .mplier (mplier_in),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // Single-cycle datapath.
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_flag_en;
  logic               big_shift;
  logic [SHAMT_W-1:0] shamt;

  // The whole of b is the shift amount: anything >= WIDTH saturates.
  assign big_shift = |(b >> SHAMT_W);
  assign shamt     = b[SHAMT_W-1:0];

  always_comb begin
    sum         = '0;
    alu_res     = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    alu_flag_en = 1'b1;
    case (bus.opcode)
      OP_ADD, OP_ADDI: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_COMP, OP_COMPI: begin
        alu_res = ~b + WIDTH'(1);
        alu_v   = (b == MOST_NEG);
      end
      OP_SUB: begin
        sum     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND:                  alu_res = a & b;
      OP_XOR:                  alu_res = a ^ b;
      OP_OR:                   alu_res = a | b;
      OP_SLL, OP_SLLI, OP_SLA: alu_res = big_shift ? '0 : (a << shamt);
      OP_SRL, OP_SRLI:         alu_res = big_shift ? '0 : (a >> shamt);
      OP_SRA:                  alu_res = big_shift ? {WIDTH{a[MSB]}}
                                                   : $unsigned($signed(a) >>> shamt);
      default:                 alu_flag_en = 1'b0;
    endcase
  end

  // Multiply finish: re-apply the sign to the full-width product.
  logic               mul_signed_q, mul_neg_q;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   prod_lo, prod_hi;
  logic               prod_ovf;

  assign prod_f   = mul_neg_q ? (~mul_product + (2*WIDTH)'(1)) : mul_product;
  assign prod_lo  = prod_f[WIDTH-1:0];
  assign prod_hi  = prod_f[2*WIDTH-1:WIDTH];
  assign prod_ovf = mul_signed_q ? (prod_hi != {WIDTH{prod_lo[MSB]}})
                                 : (prod_hi != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      bus.ready         <= 1'b1;
      bus.valid         <= 1'b0;
      bus.result        <= '0;
      bus.result_hi     <= '0;
      bus.zero_flag     <= 1'b0;
      bus.carry_flag    <= 1'b0;
      bus.sign_flag     <= 1'b0;
      bus.overflow_flag <= 1'b0;
      mul_signed_q      <= 1'b0;
      mul_neg_q         <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul(bus.opcode)) begin
              state        <= ST_MUL;
              bus.ready    <= 1'b0;
              mul_signed_q <= muls_in;
              mul_neg_q    <= muls_in && (a[MSB] != b[MSB]);
            end else begin
              bus.valid         <= 1'b1;
              bus.result        <= alu_res;
              bus.result_hi     <= '0;
              bus.zero_flag     <= alu_flag_en && (alu_res == '0);
              bus.carry_flag    <= alu_c;
              bus.sign_flag     <= alu_res[MSB];
              bus.overflow_flag <= alu_v;
            end
          end
        end
        ST_MUL: begin
          // !mul_busy here would mean the engine lost its job; fall through
          // to FIN rather than wait forever.
          if (mul_done || !mul_busy)
            state <= ST_FIN;
        end
        ST_FIN: begin
          state             <= ST_IDLE;
          bus.ready         <= 1'b1;
          bus.valid         <= 1'b1;
          bus.result        <= prod_lo;
          bus.result_hi     <= prod_hi;
          bus.zero_flag     <= (prod_f == '0);
          bus.carry_flag    <= 1'b0;
          bus.sign_flag     <= prod_hi[MSB];
          bus.overflow_flag <= prod_ovf;
        end
        default: begin
          state     <= ST_IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: requests push expected responses computed
// by a plain-arithmetic reference model; a negedge monitor pops on valid.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint IMAX = 64'sd2147483647;
  localparam longint IMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    bit z, c, s, v;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb_, sr;
    logic [63:0] u, p;
    bit mul;
    e = '{res: 32'h0, hi: 32'h0, z: 0, c: 0, s: 0, v: 0, lat: 1, acc: 0};
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    mul = 0;
    p = 64'h0;
    case (op)
      OP_ADD, OP_ADDI: begin
        u = {32'h0, a} + {32'h0, b};
        e.res = a + b; e.c = u[32];
        sr = sa + sb_; e.v = (sr > IMAX) || (sr < IMIN);
      end
      OP_COMP, OP_COMPI: begin
        e.res = 32'h0 - b; e.v = (-sb_ > IMAX);
      end
      OP_SUB: begin
        e.res = a - b; e.c = (a >= b);
        sr = sa - sb_; e.v = (sr > IMAX) || (sr < IMIN);
      end
      OP_MULU: begin
        mul = 1; p = {32'h0, a} * {32'h0, b}; e.v = (p >= 64'h1_0000_0000);
      end
      OP_MULS: begin
        mul = 1; sr = sa * sb_; p = sr; e.v = (sr > IMAX) || (sr < IMIN);
      end
      OP_AND: e.res = a & b;
      OP_XOR: e.res = a ^ b;
      OP_OR:  e.res = a | b;
      OP_SLL, OP_SLLI, OP_SLA: e.res = (b >= 32) ? 32'h0 : (a << b);
      OP_SRL, OP_SRLI:         e.res = (b >= 32) ? 32'h0 : (a >> b);
      OP_SRA: e.res = (b >= 32) ? (a[31] ? 32'hFFFF_FFFF : 32'h0) : 32'($signed(a) >>> b);
      default: e.res = 32'h0;
    endcase
    if (mul) begin
      e.res = p[31:0]; e.hi = p[63:32];
      e.z = (p == 64'h0); e.s = p[63]; e.lat = W + 2;
    end else begin
      e.z = (e.res == 32'h0); e.s = e.res[31];
    end
    return e;
  endfunction

  // Monitor: every valid must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_valid: got valid=1 result=%0h expected no outstanding request", bus.result);
      end else begin
        mon_e = sb.pop_front();
        chk("result",    bus.result,        mon_e.res);
        chk("result_hi", bus.result_hi,     mon_e.hi);
        chk("zero",      bus.zero_flag,     mon_e.z);
        chk("carry",     bus.carry_flag,    mon_e.c);
        chk("sign",      bus.sign_flag,     mon_e.s);
        chk("overflow",  bus.overflow_flag, mon_e.v);
        chk("latency",   cyc - mon_e.acc,   mon_e.lat);
      end
    end
  end

  // Drive one request at a negedge; it is accepted at the next edge iff ready.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.a = a; bus.b = b;
    acc = bus.ready;
    if (acc) begin
      e = model(op, a, b);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    for (int i = 0; i < 200; i++) begin
      drive(op, a, b, acc);
      if (acc) return;
    end
    checks++; failures++;
    $display("FAIL send_timeout: got ready=0 for 200 cycles expected acceptance");
  endtask

  // Idle cycles scramble the operand inputs to prove they were latched.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start = 1'b0; bus.opcode = 4'($urandom); bus.a = $urandom; bus.b = $urandom;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, bus.ready, 1'b1);
    chk({tag, "_valid"}, bus.valid, 1'b0);
    chk({tag, "_result"}, {bus.result_hi, bus.result}, 64'h0);
    chk({tag, "_flags"}, {bus.zero_flag, bus.carry_flag, bus.sign_flag, bus.overflow_flag}, 4'h0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return $urandom % 48;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, lowcnt;
    logic [3:0] op;
    bus.start = 1'b0; bus.opcode = 4'h0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    rst = 1'b0;

    send(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    send(OP_SUB, 32'h5, 32'h7);
    idle(2);

    // MULS -3*7: ready low while the engine runs.
    send(OP_MULS, 32'hFFFF_FFFD, 32'h7);
    lowcnt = 0;
    for (n = 0; n < 100; n++) begin
      idle(1);
      if (bus.ready) break;
      lowcnt++;
    end
    chk("muls_ready_low_cycles", lowcnt, W + 1);

    // MULU with start pulses while busy: they must be ignored.
    send(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.ready) begin
        bus.start = 1'b0;
        break;
      end
      bus.start = 1'b1; bus.opcode = 4'($urandom); bus.a = $urandom; bus.b = $urandom;
    end
    idle(1);

    send(OP_SRA, 32'h8000_0000, 32'd40);
    send(OP_SRL, 32'h8000_0000, 32'd40);
    send(OP_SLL, 32'h1, 32'd31);
    drain();

    // Reset in the middle of a multiply: no result may ever appear.
    send(OP_MULS, 32'd12345, 32'hFFFF_FD5A);
    idle(10);
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_reset_state("midmul");
    rst = 1'b0;
    idle(W + 10);
    send(OP_ADD, 32'h2, 32'h3);
    drain();

    repeat (300) begin
      op = 4'($urandom);
      send(op, rnd_val(), rnd_val());
      if ($urandom % 4 == 0) idle($urandom_range(1, 3));
    end
    drain();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule
